// File: rtl/fft_unload_pkg.sv
// Shared types and helpers for the FFT spectrum unloader.
package fft_unload_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_FIN      = 3'd3,
    ST_WAIT_CLR = 3'd4
  } unload_state_t;

  // Bit position of the 'last' flag in a packed {last, bin, data} entry.
  function automatic int pwr_last_bit(input int dw, input int n);
    return 2 * dw + n;
  endfunction

  // Number of bins swept per frame: half spectrum for real input, else all.
  function automatic int num_bins(input int len, input int half);
    return (half != 0) ? len / 2 : len;
  endfunction

endpackage

// File: rtl/fft_pwr_fifo.sv
// Synchronous FIFO holding {last, bin, power} entries between the squarer
// pipeline and the output stream. rdata reads zero while empty.
module fft_pwr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push then.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL_CNT) || do_pop);
  end

  // Pointer and occupancy bookkeeping; flush discards everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fft_spectrum_unloader.sv
// Sweeps the FFT core's DMA read port after 'done', squares each bin into
// exact power and streams {power, bin, last, exponent} downstream.
//
// Output handshake: an entry transfers on a cycle where pwr_valid && pwr_ready.
// pwr_valid never depends on pwr_ready, and pwr_data/bin/last/exp hold stable
// while pwr_valid && !pwr_ready.
module fft_spectrum_unloader
  import fft_unload_pkg::*;
#(
  parameter int FFT_LENGTH    = 1024,
  parameter int FFT_DW        = 16,
  parameter int HALF_SPECTRUM = 1,
  parameter int FIFO_DEPTH    = 4,
  localparam int FFT_N        = $clog2(FFT_LENGTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done,
  input  logic [7:0]              bfpexp,
  output logic                    fin,
  output logic                    dmaact,
  output logic [FFT_N-1:0]        dmaa,
  input  logic signed [FFT_DW-1:0] dmadr_real,
  input  logic signed [FFT_DW-1:0] dmadr_imag,
  output logic                    pwr_valid,
  input  logic                    pwr_ready,
  output logic [2*FFT_DW-1:0]     pwr_data,
  output logic [FFT_N-1:0]        pwr_bin,
  output logic                    pwr_last,
  output logic [7:0]              pwr_exp,
  output logic                    busy,
  output logic [2:0]              dbg_state
);

  localparam int NUM_BINS              = num_bins(FFT_LENGTH, HALF_SPECTRUM);
  localparam logic [FFT_N-1:0] LAST_ADDR = FFT_N'(NUM_BINS - 1);
  localparam int LB                    = pwr_last_bit(FFT_DW, FFT_N);
  localparam int EW                    = LB + 1;
  localparam int CW                    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_CNT    = (CW + 1)'(FIFO_DEPTH);

  unload_state_t state, state_nxt;

  logic [FFT_N-1:0]        ctr;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic [CW:0]             occ;
  logic                    issue;
  logic                    abort;

  // Stage 1: read issued last cycle, core data present this cycle.
  logic                    s1_valid;
  logic [FFT_N-1:0]        s1_bin;
  logic                    s1_last;

  // Stage 2: registered power, pushed into the FIFO this cycle.
  logic                    p_valid;
  logic [FFT_N-1:0]        p_bin;
  logic                    p_last;
  logic [2*FFT_DW-1:0]     p_data;

  logic signed [2*FFT_DW-1:0] re_x, im_x, sq_re, sq_im;
  logic [2*FFT_DW-1:0]        pwr_sum;
  logic [EW-1:0]              fifo_rdata;

  // A read may issue only if its result is guaranteed a FIFO slot, counting
  // every read still travelling through the squarer pipeline.
  always_comb begin
    occ   = {1'b0, fifo_count} + {1'b0, inflight};
    issue = (state == ST_READ) && done && (occ < DEPTH_CNT);
    abort = ((state == ST_READ) || (state == ST_DRAIN)) && !done;
  end

  // Next-state logic for the unload sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (done) state_nxt = ST_READ;
      ST_READ:     if (!done) state_nxt = ST_IDLE;
                   else if (issue && (ctr == LAST_ADDR)) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (!done) state_nxt = ST_IDLE;
                   else if ((inflight == '0) && fifo_empty) state_nxt = ST_FIN;
      ST_FIN:      state_nxt = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!done) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Bin address counter and frame exponent capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr     <= '0;
      pwr_exp <= '0;
    end else if (state == ST_IDLE) begin
      ctr <= '0;
      if (done) pwr_exp <= bfpexp;
    end else if (issue && (ctr != LAST_ADDR)) begin
      ctr <= ctr + FFT_N'(1);
    end
  end

  // Reads issued but not yet written into the FIFO (at most two in steady state).
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      inflight <= '0;
    end else begin
      case ({issue, p_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Exact squares: magnitude never exceeds 2^(2*FFT_DW-2) so the signed
  // product fits, and the sum of two fits unsigned in 2*FFT_DW bits.
  always_comb begin
    re_x    = {{FFT_DW{dmadr_real[FFT_DW-1]}}, dmadr_real};
    im_x    = {{FFT_DW{dmadr_imag[FFT_DW-1]}}, dmadr_imag};
    sq_re   = re_x * re_x;
    sq_im   = im_x * im_x;
    pwr_sum = $unsigned(sq_re) + $unsigned(sq_im);
  end

  // Squarer pipeline: bin tag and last flag travel alongside the data.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s1_last  <= 1'b0;
      p_valid  <= 1'b0;
      p_bin    <= '0;
      p_last   <= 1'b0;
      p_data   <= '0;
    end else begin
      s1_valid <= issue;
      s1_bin   <= ctr;
      s1_last  <= (ctr == LAST_ADDR);
      p_valid  <= s1_valid;
      p_bin    <= s1_bin;
      p_last   <= s1_last;
      p_data   <= pwr_sum;
    end
  end

  fft_pwr_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (p_valid),
    .wdata ({p_last, p_bin, p_data}),
    .pop   (pwr_valid && pwr_ready),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pwr_valid = !fifo_empty;
  assign pwr_last  = fifo_rdata[LB];
  assign pwr_bin   = fifo_rdata[LB-1 -: FFT_N];
  assign pwr_data  = fifo_rdata[2*FFT_DW-1:0];
  assign dmaact    = issue;
  assign dmaa      = ctr;
  assign fin       = (state == ST_FIN);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_fft_spectrum_unloader.sv
// Directed bench for fft_spectrum_unloader: a half-spectrum instance (A) and a
// full-spectrum instance (B), each fed by a small FFT core read-port model.
module tb_fft_spectrum_unloader;
  import fft_unload_pkg::*;

  localparam int W = 45;  // {last, bin[3:0], exp[7:0], data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Hand-computed powers: pattern 0 is (k,-k) -> 2k^2.
  int sq0 [16] = '{0, 2, 8, 18, 32, 50, 72, 98, 128, 162, 200, 242, 288, 338, 392, 450};
  // Pattern 1: extremes in bins 0/1, then (k,k+1) -> k^2+(k+1)^2.
  logic [31:0] sq1 [8] = '{32'h8000_0000, 32'h3FFF_0001, 32'd13, 32'd25,
                          32'd41, 32'd61, 32'd85, 32'd113};

  // ---------------- DUT A: FFT_LENGTH=16, half spectrum ----------------
  logic               done_a = 1'b0;
  logic [7:0]         bfpexp_a = 8'h00;
  logic               fin_a, dmaact_a, pwr_valid_a, pwr_last_a, busy_a;
  logic [3:0]         dmaa_a, pwr_bin_a;
  logic signed [15:0] dre_a = 16'sd0;
  logic signed [15:0] dim_a = 16'sd0;
  logic               pwr_ready_a = 1'b1;
  logic [31:0]        pwr_data_a;
  logic [7:0]         pwr_exp_a;
  logic [2:0]         dbg_a;

  fft_spectrum_unloader #(
    .FFT_LENGTH(16), .FFT_DW(16), .HALF_SPECTRUM(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .done(done_a), .bfpexp(bfpexp_a), .fin(fin_a),
    .dmaact(dmaact_a), .dmaa(dmaa_a), .dmadr_real(dre_a), .dmadr_imag(dim_a),
    .pwr_valid(pwr_valid_a), .pwr_ready(pwr_ready_a), .pwr_data(pwr_data_a),
    .pwr_bin(pwr_bin_a), .pwr_last(pwr_last_a), .pwr_exp(pwr_exp_a),
    .busy(busy_a), .dbg_state(dbg_a)
  );

  // ---------------- DUT B: FFT_LENGTH=16, full spectrum ----------------
  logic               done_b = 1'b0;
  logic [7:0]         bfpexp_b = 8'h02;
  logic               fin_b, dmaact_b, pwr_valid_b, pwr_last_b, busy_b;
  logic [3:0]         dmaa_b, pwr_bin_b;
  logic signed [15:0] dre_b = 16'sd0;
  logic signed [15:0] dim_b = 16'sd0;
  logic [31:0]        pwr_data_b;
  logic [7:0]         pwr_exp_b;
  logic [2:0]         dbg_b;

  fft_spectrum_unloader #(
    .FFT_LENGTH(16), .FFT_DW(16), .HALF_SPECTRUM(0), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .done(done_b), .bfpexp(bfpexp_b), .fin(fin_b),
    .dmaact(dmaact_b), .dmaa(dmaa_b), .dmadr_real(dre_b), .dmadr_imag(dim_b),
    .pwr_valid(pwr_valid_b), .pwr_ready(1'b1), .pwr_data(pwr_data_b),
    .pwr_bin(pwr_bin_b), .pwr_last(pwr_last_b), .pwr_exp(pwr_exp_b),
    .busy(busy_b), .dbg_state(dbg_b)
  );

  // ---------------- FFT core read-port model ----------------
  function automatic void core_val(input int pat, input int k,
                                   output logic signed [15:0] re,
                                   output logic signed [15:0] im);
    re = 16'(k);
    im = 16'(-k);
    if (pat == 1) begin
      if (k == 0) begin
        re = 16'sh8000;
        im = 16'sh8000;
      end else if (k == 1) begin
        re = 16'sh7FFF;
        im = 16'sh0000;
      end else begin
        im = 16'(k + 1);
      end
    end
  endfunction

  int pat_a = 0;
  int rd_cnt_a = 0;
  int rd_cnt_b = 0;

  // Read data appears the cycle after the strobe; filler otherwise.
  always @(posedge clk) begin
    logic signed [15:0] r, i;
    if (dmaact_a) begin
      core_val(pat_a, int'(dmaa_a), r, i);
      dre_a    <= r;
      dim_a    <= i;
      rd_cnt_a <= rd_cnt_a + 1;
    end else begin
      dre_a <= 16'sh5A5A;
      dim_a <= -16'sh1234;
    end
  end

  always @(posedge clk) begin
    logic signed [15:0] r, i;
    if (dmaact_b) begin
      core_val(0, int'(dmaa_b), r, i);
      dre_b    <= r;
      dim_b    <= i;
      rd_cnt_b <= rd_cnt_b + 1;
    end else begin
      dre_b <= 16'sh5A5A;
      dim_b <= -16'sh1234;
    end
  end

  // ---------------- downstream ready driver ----------------
  logic ready_rand_a  = 1'b0;
  logic ready_fixed_a = 1'b1;
  always begin
    @(posedge clk);
    #2;
    pwr_ready_a = ready_rand_a ? 1'($urandom_range(0, 1)) : ready_fixed_a;
  end

  // ---------------- scoreboard / monitors ----------------
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  logic         hold_a = 1'b0;
  logic [W-1:0] held_a = '0;
  int first_rd_a = -1, first_val_a = -1, first_hs_a = -1, last_hs_a = -1;
  int fin_cnt_a = 0;

  always @(negedge clk) begin
    logic [W-1:0] got, e;
    got = {pwr_last_a, pwr_bin_a, pwr_exp_a, pwr_data_a};
    if (!rst) begin
      if (hold_a && busy_a) begin
        checks++;
        if (!pwr_valid_a || (got !== held_a)) begin
          failures++;
          $display("FAIL stall_hold_a: got valid=%0b %h, required valid=1 %h", pwr_valid_a, got, held_a);
        end
      end
      if (pwr_valid_a && pwr_ready_a) begin
        checks++;
        if (exp_q_a.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out_a: got %h, required no output", got);
        end else begin
          e = exp_q_a.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL out_a: got %h, required %h", got, e);
          end
        end
        if (first_hs_a < 0) first_hs_a = cyc;
        last_hs_a = cyc;
      end
      if (dmaact_a) begin
        checks++;
        if (dmaa_a > 4'd7) begin
          failures++;
          $display("FAIL dmaa_range_a: got %0d, required <= 7", dmaa_a);
        end
        if (first_rd_a < 0) first_rd_a = cyc;
      end
      if (pwr_valid_a && (first_val_a < 0)) first_val_a = cyc;
      if (fin_a) fin_cnt_a++;
    end
    hold_a = !rst && pwr_valid_a && !pwr_ready_a;
    held_a = got;
  end

  always @(negedge clk) begin
    logic [W-1:0] got, e;
    got = {pwr_last_b, pwr_bin_b, pwr_exp_b, pwr_data_b};
    if (!rst && pwr_valid_b) begin
      checks++;
      if (exp_q_b.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out_b: got %h, required no output", got);
      end else begin
        e = exp_q_b.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL out_b: got %h, required %h", got, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_fin"}, 64'(fin_a), 0);
    chk({tag, "_dmaact"}, 64'(dmaact_a), 0);
    chk({tag, "_dmaa"}, 64'(dmaa_a), 0);
    chk({tag, "_pwr_valid"}, 64'(pwr_valid_a), 0);
    chk({tag, "_pwr_data"}, 64'(pwr_data_a), 0);
    chk({tag, "_pwr_bin"}, 64'(pwr_bin_a), 0);
    chk({tag, "_pwr_last"}, 64'(pwr_last_a), 0);
    chk({tag, "_pwr_exp"}, 64'(pwr_exp_a), 0);
    chk({tag, "_busy"}, 64'(busy_a), 0);
  endtask

  task automatic push_frame_a(input int pat, input logic [7:0] be);
    logic [31:0] d;
    for (int k = 0; k < 8; k++) begin
      d = (pat == 1) ? sq1[k] : 32'(sq0[k]);
      exp_q_a.push_back({(k == 7), 4'(k), be, d});
    end
  endtask

  // Runs one full frame on A; done is held 'hold_after' cycles past fin.
  task automatic run_frame_a(input int pat, input logic [7:0] be, input int hold_after);
    int  fin0, rd0;
    logic got_fin;
    pat_a = pat;
    bfpexp_a = be;
    push_frame_a(pat, be);
    first_rd_a = -1; first_val_a = -1; first_hs_a = -1; last_hs_a = -1;
    fin0 = fin_cnt_a;
    got_fin = 1'b0;
    done_a = 1'b1;
    for (int c = 0; (c < 400) && !got_fin; c++) begin
      @(posedge clk); #1;
      if (fin_a) got_fin = 1'b1;
    end
    chk("fin_seen", 64'(got_fin), 1);
    chk("queue_empty_at_fin", 64'(exp_q_a.size()), 0);
    chk("fin_after_last_hs", 64'(last_hs_a < cyc), 1);
    @(posedge clk); #1;
    chk("fin_one_cycle", 64'(fin_a), 0);
    rd0 = rd_cnt_a;
    for (int c = 0; c < hold_after; c++) begin
      @(posedge clk); #1;
    end
    chk("no_retrigger_reads", 64'(rd_cnt_a - rd0), 0);
    chk("fin_count", 64'(fin_cnt_a - fin0), 1);
    done_a = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_done_low", 64'(busy_a), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rd0, fin0;
    logic got_fin;

    repeat (3) @(posedge clk);
    #1;
    check_reset_a("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: (k,-k) frame, full rate
    run_frame_a(0, 8'hFD, 0);
    chk("first_word_latency", 64'(first_val_a - first_rd_a), 3);
    chk("back_to_back", 64'(last_hs_a - first_hs_a), 7);

    // 2: extreme values
    run_frame_a(1, 8'h05, 0);

    // 3: random backpressure
    ready_rand_a = 1'b1;
    run_frame_a(0, 8'hF0, 0);
    ready_rand_a = 1'b0;
    @(posedge clk); #1;

    // 4: full spectrum on B
    for (int k = 0; k < 16; k++) exp_q_b.push_back({(k == 15), 4'(k), 8'h02, 32'(sq0[k])});
    rd0 = rd_cnt_b;
    got_fin = 1'b0;
    done_b = 1'b1;
    for (int c = 0; (c < 400) && !got_fin; c++) begin
      @(posedge clk); #1;
      if (fin_b) got_fin = 1'b1;
    end
    chk("fin_seen_b", 64'(got_fin), 1);
    chk("reads_b", 64'(rd_cnt_b - rd0), 16);
    chk("queue_empty_b", 64'(exp_q_b.size()), 0);
    done_b = 1'b0;
    @(posedge clk); #1;

    // 5: abort after three reads, entries stalled in the FIFO
    ready_fixed_a = 1'b0;
    pat_a = 0;
    bfpexp_a = 8'hFD;
    rd0 = rd_cnt_a;
    fin0 = fin_cnt_a;
    done_a = 1'b1;
    for (int c = 0; (c < 50) && (rd_cnt_a - rd0 < 3); c++) begin
      @(posedge clk); #1;
    end
    done_a = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid_low", 64'(pwr_valid_a), 0);
    chk("abort_busy_low", 64'(busy_a), 0);
    chk("abort_reads", 64'(rd_cnt_a - rd0), 3);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_fin", 64'(fin_cnt_a - fin0), 0);
    ready_fixed_a = 1'b1;
    @(posedge clk); #1;
    run_frame_a(0, 8'hFD, 0);

    // 6a: reset while draining
    push_frame_a(0, 8'h11);
    bfpexp_a = 8'h11;
    rd0 = rd_cnt_a;
    fin0 = fin_cnt_a;
    done_a = 1'b1;
    for (int c = 0; (c < 100) && (rd_cnt_a - rd0 < 8); c++) begin
      @(posedge clk); #1;
    end
    ready_fixed_a = 1'b0;
    @(posedge clk); #1;
    chk("in_drain", 64'(dbg_a), 64'(ST_DRAIN));
    rst = 1'b1;
    done_a = 1'b0;
    @(posedge clk); #1;
    check_reset_a("midrst");
    exp_q_a.delete();
    rst = 1'b0;
    ready_fixed_a = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_fin", 64'(fin_cnt_a - fin0), 0);

    // 6b: done held after fin, then a fresh frame
    run_frame_a(0, 8'hFD, 5);
    run_frame_a(1, 8'h80, 0);

    chk("queue_a_drained", 64'(exp_q_a.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
